regfile_wb_sink: RTL

REGFILE_WB_SINK -- requirements
Module: regfile_wb_sink

---
 rtl/regfile_wb_sink.sv | 73 +++++++
 1 files changed

// File: rtl/regfile_wb_sink.sv
// regfile_wb_sink: register file with write-back sink, registered reads and per-register busy scoreboard (optional same-cycle bypass via REGFILE_BYPASS_EN)
module regfile_wb_sink #(
  parameter int REGS  = 32,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] regs_data_in,
  input  logic [7:0]       regs_wr_id_in,
  input  logic             regs_write_in,
  input  logic [7:0]       rs1_id_in,
  input  logic [7:0]       rs2_id_in,
  output logic [WIDTH-1:0] rs1_data_out,
  output logic [WIDTH-1:0] rs2_data_out,
  input  logic             issue_in,
  input  logic [7:0]       issue_rd_in,
  output logic             hazard_out
);
  localparam int AW = (REGS > 1) ? $clog2(REGS) : 1;
  localparam logic [8:0] REGS9 = 9'(REGS);
  logic [WIDTH-1:0] regs_q [REGS];
  logic [WIDTH-1:0] regs_d [REGS];
  logic [REGS-1:0]  busy_q, busy_d;
  logic [WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic             wr_ok, iss_ok, rs1_ok, rs2_ok, rs1_fwd, rs2_fwd;
  assign wr_ok   = regs_write_in && regs_wr_id_in != 8'd0 && {1'b0, regs_wr_id_in} < REGS9;
  assign iss_ok  = issue_in && issue_rd_in != 8'd0 && {1'b0, issue_rd_in} < REGS9;
  assign rs1_ok  = rs1_id_in != 8'd0 && {1'b0, rs1_id_in} < REGS9;
  assign rs2_ok  = rs2_id_in != 8'd0 && {1'b0, rs2_id_in} < REGS9;
`ifdef REGFILE_BYPASS_EN
  assign rs1_fwd = wr_ok && regs_wr_id_in == rs1_id_in;
  assign rs2_fwd = wr_ok && regs_wr_id_in == rs2_id_in;
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
`endif
  assign rs1_data_out = rs1_q;
  assign rs2_data_out = rs2_q;
  // a source is hazardous while busy, unless the bypass delivers its value this cycle
  always_comb begin
    hazard_out = (rs1_ok && busy_q[rs1_id_in[AW-1:0]] && !rs1_fwd) ||
                 (rs2_ok && busy_q[rs2_id_in[AW-1:0]] && !rs2_fwd);
  end
  // next register contents and read data; register 0 is pinned to zero
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[regs_wr_id_in[AW-1:0]] = regs_data_in;
    regs_d[0] = '0;
    rs1_d = !rs1_ok ? '0 : rs1_fwd ? regs_data_in : regs_q[rs1_id_in[AW-1:0]];
    rs2_d = !rs2_ok ? '0 : rs2_fwd ? regs_data_in : regs_q[rs2_id_in[AW-1:0]];
  end
  // busy bits: an issue sets (wins over a same-cycle write-back), a committed write clears
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) busy_d[regs_wr_id_in[AW-1:0]] = 1'b0;
    if (iss_ok) busy_d[issue_rd_in[AW-1:0]] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // state update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
    end
  end
endmodule
